ext_mem_responder: RTL and testbench
====================================

# ext_mem_responder

Memory-side responder for the CPU's external bus. It owns a 256 x 16 word memory, services the single-outstanding read/write requests issued by the register datapath (8-bit address, 16-bit data), and returns data with a one-cycle ready pulse after a programmable wait. Before the CPU runs, a streaming loader port fills the memory from address 0. When loading completes, the block raises the CPU start signal consumed by the register top.

## Interface
- WAIT_CYCLES, default 2: extra access latency in cycles, legal range 0..15.
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_mem_addr  input  8  word address from the CPU MAR.
- i_mem_wdata  input  16  write data from the CPU MBR.
- i_mem_rd  input  1  read request strobe.
- i_mem_wr  input  1  write request strobe.
- o_mem_rdata  output  16  read data to the CPU MBR.
- o_mem_ready  output  1  one-cycle completion pulse for a read or a write.
- o_mem_busy  output  1  high while a request is in flight.
- o_mem_err  output  1  one-cycle pulse on an illegal or dropped request.
- i_load_valid  input  1  loader word valid.
- i_load_data  input  16  loader word.
- i_load_last  input  1  ends loading; may accompany a final valid word or arrive alone.
- o_cpu_start  output  1  level; high once loading is done, drives ctrl_cpu_start.

## Operation
- FSM states: LOAD, IDLE, WAIT, RESP.
- Reset: state goes to LOAD, load_ptr=0, wait counter=0. All outputs are 0, including o_mem_rdata. Memory contents are not cleared.
- LOAD:
  - On each i_load_valid, write mem[load_ptr]=i_load_data and increment load_ptr (8-bit).
  - On i_load_last, or on a valid write at load_ptr=255, go to IDLE. If i_load_valid is high in the same cycle, the word is written first.
  - CPU strobes received in LOAD are ignored and pulse o_mem_err.
- IDLE:
  - o_cpu_start=1 from here on, until the next reset.
  - i_mem_rd xor i_mem_wr: latch address, write data and direction; set o_mem_busy=1; load counter=WAIT_CYCLES; go to WAIT.
  - i_mem_rd and i_mem_wr together: no access is made, o_mem_err pulses, state stays IDLE.
- WAIT:
  - Decrement the counter each cycle. When the counter is 0, go to RESP. With WAIT_CYCLES=0, WAIT lasts exactly one cycle.
  - Strobes received in WAIT are dropped and pulse o_mem_err. The latched request is unaffected.
- RESP (entered on the edge that leaves WAIT):
  - On that same edge: a write stores mem[addr]=wdata; a read registers o_mem_rdata=mem[addr].
  - o_mem_ready=1 for one cycle, o_mem_busy=0, then go to IDLE.
  - A strobe arriving during RESP is accepted as a new request on the edge that leaves RESP.
- o_mem_rdata holds its value until the next read completes. Writes do not change it.
- The address is 8 bits and the full 256-word space is valid. No wrap handling is needed beyond natural 8-bit overflow of load_ptr, which also ends loading.

## Timing
- Request sampled at edge k in IDLE: o_mem_busy is high after edge k. o_mem_ready is high for the cycle after edge k+1+WAIT_CYCLES.
- Read data is valid in the same cycle as o_mem_ready.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Loader: one word per cycle. o_cpu_start rises the cycle after the edge that samples i_load_last, or after the edge that writes address 255.
- o_mem_err is a registered pulse, asserted the cycle after the offending edge.
- Reset asserted mid-access: the pending write is not performed, o_mem_ready does not pulse, and the FSM returns to LOAD. Memory retains its contents.

## Test plan
- Load 0x1234, 0xABCD, 0x0F0F, with last on the third word → o_cpu_start=1 one cycle after the third edge. Reads of addresses 0, 1, 2 return the three words, each ready pulse arriving WAIT_CYCLES+2 cycles after its strobe.
- WAIT_CYCLES=0: write 0xBEEF to 0x80, then read 0x80 → ready pulses 2 cycles after each strobe; rdata=0xBEEF; rdata is unchanged by the write itself.
- i_mem_rd and i_mem_wr both high in IDLE with addr 0x05 → one o_mem_err pulse, no ready, mem[0x05] unchanged, busy stays 0.
- Read strobe on the cycle after a read is accepted (during WAIT) → o_mem_err pulses, only one ready is produced, rdata comes from the first address.
- Stream 256 valid words with no i_load_last → loading ends after address 255, and o_cpu_start rises. A 257th valid word is ignored as load data.
- Assert i_rst during WAIT of a write of 0x5555 to 0x10 → no ready, outputs reset to 0, state is LOAD. After i_load_last alone, a read of 0x10 returns the old contents.

Source files
------------

// File: rtl/ext_mem_responder.sv
// ext_mem_responder
// Memory-side responder for the CPU external bus. Holds a 256 x 16 word
// memory that a streaming loader fills from address 0 before the CPU runs.
// After loading it serves one outstanding read or write at a time, answering
// with a one-cycle ready pulse after WAIT_CYCLES extra cycles of latency.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_mem_addr        word address from the CPU MAR
//   i_mem_wdata       write data from the CPU MBR
//   i_mem_rd/i_mem_wr request strobes (exactly one must be high)
//   o_mem_rdata       registered read data, held until the next read completes
//   o_mem_ready       one-cycle completion pulse
//   o_mem_busy        high while a request is in flight
//   o_mem_err         one-cycle pulse for an illegal or dropped request
//   i_load_valid      loader word valid
//   i_load_data       loader word
//   i_load_last       ends loading, with or without a final word
//   o_cpu_start       level, high once loading has finished
module ext_mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_mem_addr,
    input  logic [15:0] i_mem_wdata,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    output logic [15:0] o_mem_rdata,
    output logic        o_mem_ready,
    output logic        o_mem_busy,
    output logic        o_mem_err,
    input  logic        i_load_valid,
    input  logic [15:0] i_load_data,
    input  logic        i_load_last,
    output logic        o_cpu_start
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  load_ptr_q, load_ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        start_q, start_d;

    logic [15:0] mem [256];

    logic load_we;
    logic acc_we;
    logic single_req;
    logic any_req;

    assign single_req = i_mem_rd ^ i_mem_wr;
    assign any_req    = i_mem_rd | i_mem_wr;

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        start_d    = start_q;
        load_we    = 1'b0;
        acc_we     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // The CPU should not be issuing requests yet; flag them.
                if (any_req) begin
                    err_d = 1'b1;
                end
                if (i_load_valid) begin
                    load_we    = 1'b1;
                    load_ptr_d = load_ptr_q + 8'd1;
                end
                // Writing the last address ends loading just like i_load_last.
                if (i_load_last || (i_load_valid && load_ptr_q == 8'hFF)) begin
                    state_d = ST_IDLE;
                    start_d = 1'b1;
                end
            end

            // RESP accepts a new request exactly like IDLE so that
            // back-to-back accesses need no idle cycle in between.
            ST_IDLE, ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (single_req) begin
                    addr_d  = i_mem_addr;
                    wdata_d = i_mem_wdata;
                    is_wr_d = i_mem_wr;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_WAIT;
                end else if (any_req) begin
                    err_d = 1'b1;
                end
            end

            ST_WAIT: begin
                // Only one request may be outstanding; extra strobes are dropped.
                if (any_req) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    if (is_wr_q) begin
                        acc_we = 1'b1;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= 8'd0;
            cnt_q      <= 4'd0;
            addr_q     <= 8'd0;
            wdata_q    <= 16'd0;
            is_wr_q    <= 1'b0;
            rdata_q    <= 16'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            start_q    <= start_d;
        end
    end

    // Memory is never cleared; reset only blocks a write on its edge so a
    // pending access aborted by reset leaves the contents untouched.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (load_we) begin
                mem[load_ptr_q] <= i_load_data;
            end else if (acc_we) begin
                mem[addr_q] <= wdata_q;
            end
        end
    end

    assign o_mem_rdata = rdata_q;
    assign o_mem_ready = ready_q;
    assign o_mem_busy  = busy_q;
    assign o_mem_err   = err_q;
    assign o_cpu_start = start_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder
// Self-checking bench for ext_mem_responder. Two instances run side by side:
// index 0 uses the default latency of 2 extra cycles, index 1 uses zero.
// A word-level reference model (memory image, load pointer, last read value)
// predicts every observed output.
module tb_ext_mem_responder;

    localparam int WAIT0 = 2;
    localparam int WAIT1 = 0;

    logic        clk;
    logic        rst        [2];
    logic [7:0]  mem_addr   [2];
    logic [15:0] mem_wdata  [2];
    logic        mem_rd     [2];
    logic        mem_wr     [2];
    logic [15:0] mem_rdata  [2];
    logic        mem_ready  [2];
    logic        mem_busy   [2];
    logic        mem_err    [2];
    logic        load_valid [2];
    logic [15:0] load_data  [2];
    logic        load_last  [2];
    logic        cpu_start  [2];

    int vec_count;
    int miscompares;

    // Reference model state
    logic [15:0] ref_mem     [2][256];
    logic [15:0] ref_rdata   [2];
    int          ref_ptr     [2];
    bit          ref_loading [2];
    int          known_q[$];

    ext_mem_responder #(.WAIT_CYCLES(WAIT0)) dut0 (
        .i_clk        (clk),
        .i_rst        (rst[0]),
        .i_mem_addr   (mem_addr[0]),
        .i_mem_wdata  (mem_wdata[0]),
        .i_mem_rd     (mem_rd[0]),
        .i_mem_wr     (mem_wr[0]),
        .o_mem_rdata  (mem_rdata[0]),
        .o_mem_ready  (mem_ready[0]),
        .o_mem_busy   (mem_busy[0]),
        .o_mem_err    (mem_err[0]),
        .i_load_valid (load_valid[0]),
        .i_load_data  (load_data[0]),
        .i_load_last  (load_last[0]),
        .o_cpu_start  (cpu_start[0])
    );

    ext_mem_responder #(.WAIT_CYCLES(WAIT1)) dut1 (
        .i_clk        (clk),
        .i_rst        (rst[1]),
        .i_mem_addr   (mem_addr[1]),
        .i_mem_wdata  (mem_wdata[1]),
        .i_mem_rd     (mem_rd[1]),
        .i_mem_wr     (mem_wr[1]),
        .o_mem_rdata  (mem_rdata[1]),
        .o_mem_ready  (mem_ready[1]),
        .o_mem_busy   (mem_busy[1]),
        .o_mem_err    (mem_err[1]),
        .i_load_valid (load_valid[1]),
        .i_load_data  (load_data[1]),
        .i_load_last  (load_last[1]),
        .o_cpu_start  (cpu_start[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waitOf(input int d);
        return (d == 0) ? WAIT0 : WAIT1;
    endfunction

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present strobes for one edge, then release them.
    task automatic applyStimulus(input int d, input logic rd, input logic wr,
                                 input logic [7:0] addr, input logic [15:0] wdata);
        mem_rd[d]    = rd;
        mem_wr[d]    = wr;
        mem_addr[d]  = addr;
        mem_wdata[d] = wdata;
        tick();
        mem_rd[d] = 1'b0;
        mem_wr[d] = 1'b0;
    endtask

    task automatic resetModel(input int d);
        ref_ptr[d]     = 0;
        ref_rdata[d]   = 16'h0000;
        ref_loading[d] = 1'b1;
    endtask

    // One loader cycle; the model decides whether the word lands.
    task automatic loadWord(input int d, input logic valid, input logic [15:0] data, input logic last);
        load_valid[d] = valid;
        load_data[d]  = data;
        load_last[d]  = last;
        tick();
        load_valid[d] = 1'b0;
        load_last[d]  = 1'b0;
        if (ref_loading[d]) begin
            if (valid) begin
                ref_mem[d][ref_ptr[d]] = data;
                if (ref_ptr[d] == 255) ref_loading[d] = 1'b0;
                ref_ptr[d] = (ref_ptr[d] + 1) % 256;
            end
            if (last) ref_loading[d] = 1'b0;
        end
        checkOutput("cpu_start", 16'(cpu_start[d]), 16'(!ref_loading[d]));
    endtask

    // Full access: ready must appear exactly WAIT+2 cycles after the strobe.
    task automatic doAccess(input int d, input bit is_write, input logic [7:0] addr, input logic [15:0] wdata);
        applyStimulus(d, !is_write, is_write, addr, wdata);
        for (int c = 0; c <= waitOf(d); c++) begin
            checkOutput("busy_in_flight", 16'(mem_busy[d]), 16'h1);
            checkOutput("ready_early", 16'(mem_ready[d]), 16'h0);
            tick();
        end
        if (is_write) ref_mem[d][addr] = wdata;
        else          ref_rdata[d] = ref_mem[d][addr];
        checkOutput("ready_pulse", 16'(mem_ready[d]), 16'h1);
        checkOutput("busy_at_ready", 16'(mem_busy[d]), 16'h0);
        checkOutput("rdata", mem_rdata[d], ref_rdata[d]);
        checkOutput("err_clean", 16'(mem_err[d]), 16'h0);
        tick();
        checkOutput("ready_one_cycle", 16'(mem_ready[d]), 16'h0);
    endtask

    initial begin
        logic [7:0]  a;
        logic [15:0] v;
        logic [15:0] first_word;
        vec_count   = 0;
        miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; mem_addr[d] = 8'h00; mem_wdata[d] = 16'h0000;
            mem_rd[d] = 1'b0; mem_wr[d] = 1'b0;
            load_valid[d] = 1'b0; load_data[d] = 16'h0000; load_last[d] = 1'b0;
            resetModel(d);
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_rdata", mem_rdata[d], 16'h0000);
            checkOutput("rst_ready", 16'(mem_ready[d]), 16'h0);
            checkOutput("rst_busy", 16'(mem_busy[d]), 16'h0);
            checkOutput("rst_err", 16'(mem_err[d]), 16'h0);
            checkOutput("rst_start", 16'(cpu_start[d]), 16'h0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        $display("[TB] reset released");

        // CPU strobe while loading is flagged and ignored
        applyStimulus(0, 1'b1, 1'b0, 8'h00, 16'h0000);
        checkOutput("load_strobe_err", 16'(mem_err[0]), 16'h1);
        checkOutput("load_strobe_busy", 16'(mem_busy[0]), 16'h0);
        tick();
        checkOutput("load_strobe_err_end", 16'(mem_err[0]), 16'h0);

        // Three-word load with last on the third word
        loadWord(0, 1'b1, 16'h1234, 1'b0);
        loadWord(0, 1'b1, 16'hABCD, 1'b0);
        loadWord(0, 1'b1, 16'h0F0F, 1'b1);
        doAccess(0, 1'b0, 8'h00, 16'h0000);
        doAccess(0, 1'b0, 8'h01, 16'h0000);
        doAccess(0, 1'b0, 8'h02, 16'h0000);
        known_q = '{0, 1, 2};

        // Zero-latency instance: last alone, write then read 0x80
        loadWord(1, 1'b0, 16'h0000, 1'b1);
        doAccess(1, 1'b1, 8'h80, 16'hBEEF);
        doAccess(1, 1'b0, 8'h80, 16'h0000);

        // Both strobes together in IDLE: error only, memory untouched
        doAccess(0, 1'b1, 8'h05, 16'h0505);
        known_q.push_back(5);
        applyStimulus(0, 1'b1, 1'b1, 8'h05, 16'hFFFF);
        checkOutput("both_err", 16'(mem_err[0]), 16'h1);
        checkOutput("both_busy", 16'(mem_busy[0]), 16'h0);
        checkOutput("both_ready", 16'(mem_ready[0]), 16'h0);
        tick();
        checkOutput("both_err_end", 16'(mem_err[0]), 16'h0);
        checkOutput("both_ready_late", 16'(mem_ready[0]), 16'h0);
        doAccess(0, 1'b0, 8'h05, 16'h0000);

        // Second read strobe while the first is waiting is dropped
        applyStimulus(0, 1'b1, 1'b0, 8'h01, 16'h0000);
        applyStimulus(0, 1'b1, 1'b0, 8'h02, 16'h0000);
        checkOutput("drop_err", 16'(mem_err[0]), 16'h1);
        checkOutput("drop_busy", 16'(mem_busy[0]), 16'h1);
        for (int c = 0; c < WAIT0; c++) begin
            tick();
            checkOutput("drop_ready", 16'(mem_ready[0]), 16'((c == WAIT0 - 1) ? 1 : 0));
        end
        ref_rdata[0] = ref_mem[0][1];
        checkOutput("drop_rdata", mem_rdata[0], ref_rdata[0]);
        tick();
        checkOutput("drop_single_ready", 16'(mem_ready[0]), 16'h0);
        tick();
        checkOutput("drop_no_second_ready", 16'(mem_ready[0]), 16'h0);

        // Randomized accesses against the model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 8'($urandom_range(0, 255));
                v = 16'($urandom);
                doAccess(0, 1'b1, a, v);
                known_q.push_back(int'(a));
            end else begin
                a = 8'(known_q[$urandom_range(0, known_q.size() - 1)]);
                doAccess(0, 1'b0, a, 16'h0000);
            end
        end

        // Full 256-word stream with no last marker
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        resetModel(0);
        for (int i = 0; i < 256; i++) begin
            loadWord(0, 1'b1, 16'($urandom), 1'b0);
        end
        first_word = ref_mem[0][0];
        loadWord(0, 1'b1, 16'hDEAD, 1'b0);
        doAccess(0, 1'b0, 8'h00, 16'h0000);
        checkOutput("extra_word_ignored", mem_rdata[0], first_word);
        doAccess(0, 1'b0, 8'hFF, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            doAccess(0, 1'b0, 8'($urandom_range(0, 255)), 16'h0000);
        end

        // Reset during WAIT of a write: the write must not land
        applyStimulus(0, 1'b0, 1'b1, 8'h10, 16'h5555);
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        resetModel(0);
        checkOutput("abort_ready", 16'(mem_ready[0]), 16'h0);
        checkOutput("abort_busy", 16'(mem_busy[0]), 16'h0);
        checkOutput("abort_rdata", mem_rdata[0], 16'h0000);
        checkOutput("abort_start", 16'(cpu_start[0]), 16'h0);
        tick();
        checkOutput("abort_no_ready", 16'(mem_ready[0]), 16'h0);
        tick();
        checkOutput("abort_still_no_ready", 16'(mem_ready[0]), 16'h0);
        loadWord(0, 1'b0, 16'h0000, 1'b1);
        doAccess(0, 1'b0, 8'h10, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
